// File: rtl/fxp40s_normalizer_pkg.sv
// Shared fxp40s definitions: field widths, exponent bias and the shift-to-exponent helper.
package fxp40s_normalizer_pkg;

  localparam int FXP40S_WIDTH    = 40;
  localparam int FXP40S_ADDR     = 6;
  localparam int FXP40S_SIGN     = 39;
  localparam int FXP40S_MAG      = 39;
  localparam int FXP40S_LSB_POW  = -24;
  localparam int FXP40S_EXP_BIAS = 15;
  localparam int FXP40S_SHIFT_W  = 6;
  localparam int FXP40S_EXP_W    = 7;

  typedef logic [FXP40S_WIDTH-1:0] fxp40s_t;

  // Exponent of the normalized mantissa: bias minus the applied left shift.
  function automatic logic [FXP40S_EXP_W-1:0] exp_from_shift(input logic [FXP40S_SHIFT_W-1:0] s);
    return FXP40S_EXP_W'(FXP40S_EXP_BIAS) - {1'b0, s};
  endfunction

endpackage

// File: rtl/fxp40s_normalizer_lsc.sv
// fxp40s_lsc: combinational leading-sign counter (redundant sign bits below bit 39).
module fxp40s_lsc
  import fxp40s_normalizer_pkg::*;
(
  input  logic [FXP40S_WIDTH-1:0]   i_data,
  output logic [FXP40S_SHIFT_W-1:0] o_count
);

  logic [FXP40S_MAG-1:0] w_diff;

  assign w_diff = i_data[FXP40S_MAG-1:0] ^ {FXP40S_MAG{i_data[FXP40S_SIGN]}};

  // Highest differing bit wins because later iterations overwrite lower ones.
  always_comb begin
    o_count = 6'd39;
    for (int i = 0; i < FXP40S_MAG; i++) begin
      o_count = w_diff[i] ? 6'(38 - i) : o_count;
    end
  end

endmodule

// File: rtl/fxp40s_normalizer.sv
// fxp40s_normalizer: 3-stage leading-sign normalizer with global stall.
// Optional canonical-zero output enabled by `define FXP40S_NORM_ZERO_EN.
module fxp40s_normalizer
  import fxp40s_normalizer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FXP40S_WIDTH-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FXP40S_WIDTH-1:0]   out_mant,
  output logic [FXP40S_SHIFT_W-1:0] out_shift,
  output logic [FXP40S_EXP_W-1:0]   out_exp
`ifdef FXP40S_NORM_ZERO_EN
  ,
  output logic                      out_zero
`endif
);

  logic                      w_advance;
  logic                      r1_valid;
  logic [FXP40S_WIDTH-1:0]   r1_data;
  logic                      r2_valid;
  logic [FXP40S_WIDTH-1:0]   r2_data;
  logic [FXP40S_SHIFT_W-1:0] r2_shift;
  logic [FXP40S_SHIFT_W-1:0] w_count;
  logic [FXP40S_SHIFT_W-1:0] w_shift_s2;
  logic [FXP40S_WIDTH-1:0]   w_coarse;
  logic [FXP40S_WIDTH-1:0]   w_fine;

  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;

  fxp40s_lsc u_lsc (
    .i_data  (r1_data),
    .o_count (w_count)
  );

`ifdef FXP40S_NORM_ZERO_EN
  logic r2_zero;
  logic w_zero_s2;
  assign w_zero_s2  = (r1_data == 40'd0);
  assign w_shift_s2 = w_zero_s2 ? 6'd0 : w_count;
`else
  assign w_shift_s2 = w_count;
`endif

  // Coarse shift by multiples of 8, then the fine 0..7 remainder in S3.
  assign w_coarse = r1_data << {w_shift_s2[5:3], 3'b000};
  assign w_fine   = r2_data << r2_shift[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_data  <= 40'd0;
    end else if (w_advance) begin
      r1_valid <= in_valid;
      r1_data  <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_data  <= 40'd0;
      r2_shift <= 6'd0;
`ifdef FXP40S_NORM_ZERO_EN
      r2_zero  <= 1'b0;
`endif
    end else if (w_advance) begin
      r2_valid <= r1_valid;
      r2_data  <= w_coarse;
      r2_shift <= w_shift_s2;
`ifdef FXP40S_NORM_ZERO_EN
      r2_zero  <= w_zero_s2;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mant  <= 40'd0;
      out_shift <= 6'd0;
      out_exp   <= 7'd0;
`ifdef FXP40S_NORM_ZERO_EN
      out_zero  <= 1'b0;
`endif
    end else if (w_advance) begin
      out_valid <= r2_valid;
      out_mant  <= w_fine;
      out_shift <= r2_shift;
`ifdef FXP40S_NORM_ZERO_EN
      out_exp   <= r2_zero ? 7'd0 : exp_from_shift(r2_shift);
      out_zero  <= r2_zero;
`else
      out_exp   <= exp_from_shift(r2_shift);
`endif
    end
  end

endmodule
